// File: rtl/fsm_aquaculture_pkg.sv
// rtl/fsm_aquaculture_pkg.sv - state encodings, output patterns and defaults for fsm_aquaculture
// Output pattern bit order: {pump, aerator, valve, heater, uv, feeder}.
package fsm_aquaculture_pkg;

    localparam int RECOVERY_CYCLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        NORMAL   = 2'b00,
        WARNING  = 2'b01,
        CRITICAL = 2'b10,
        RECOVERY = 2'b11
    } state_t;

    localparam logic [5:0] OUT_NORMAL   = 6'b110001;
    localparam logic [5:0] OUT_WARNING  = 6'b110010;
    localparam logic [5:0] OUT_CRITICAL = 6'b111110;
    localparam logic [5:0] OUT_RECOVERY = 6'b110010;

    function automatic logic [5:0] state_pattern(input state_t s);
        logic [5:0] p;
        case (s)
            NORMAL:   p = OUT_NORMAL;
            WARNING:  p = OUT_WARNING;
            CRITICAL: p = OUT_CRITICAL;
            default:  p = OUT_RECOVERY;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - 1-bit two-flop synchronizer
// Ports: clk, rst_n (async active-low), d (asynchronous input), q (synchronized output).
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fsm_aquaculture.sv
// rtl/fsm_aquaculture.sv - water-quality control FSM for an aquaculture tank
// Ports: clk, rst_n (async active-low), I1/I0 (asynchronous condition code),
//        pump, aerator, valve, heater, uv, feeder (registered Moore outputs),
//        state (current state encoding).
module fsm_aquaculture
    import fsm_aquaculture_pkg::*;
#(
    parameter int RECOVERY_CYCLES = RECOVERY_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       I1,
    input  logic       I0,
    output logic       pump,
    output logic       aerator,
    output logic       valve,
    output logic       heater,
    output logic       uv,
    output logic       feeder,
    output logic [1:0] state
);

    localparam logic [7:0] LAST_COUNT = 8'(RECOVERY_CYCLES - 1);

    logic       i1_sync;
    logic       i0_sync;
    logic [1:0] code;
    logic       bad;

    state_t     state_q;
    state_t     state_next;
    logic [7:0] cnt_q;
    logic [7:0] cnt_next;
    logic [5:0] out_q;
    logic [5:0] out_next;

    sync_2ff u_sync_i1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (I1),
        .q     (i1_sync)
    );

    sync_2ff u_sync_i0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (I0),
        .q     (i0_sync)
    );

    assign code = {i1_sync, i0_sync};
    // Sensor fault (11) is handled exactly like bad water (10).
    assign bad  = code[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORMAL;
            cnt_q   <= 8'd0;
            out_q   <= 6'b000000;
        end else begin
            state_q <= state_next;
            cnt_q   <= cnt_next;
            out_q   <= out_next;
        end
    end

    // The counter is only meaningful in RECOVERY; every other path clears it,
    // so entry from CRITICAL always starts the dwell at zero.
    always_comb begin
        state_next = state_q;
        cnt_next   = 8'd0;
        case (state_q)
            NORMAL, WARNING: begin
                if (bad)          state_next = CRITICAL;
                else if (code[0]) state_next = WARNING;
                else              state_next = NORMAL;
            end
            CRITICAL: begin
                if (!bad) state_next = RECOVERY;
            end
            RECOVERY: begin
                if (bad) begin
                    state_next = CRITICAL;
                end else if (cnt_q == LAST_COUNT) begin
                    state_next = code[0] ? WARNING : NORMAL;
                end else begin
                    state_next = RECOVERY;
                    cnt_next   = cnt_q + 8'd1;
                end
            end
            default: state_next = NORMAL;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they move on
    // the same edge as the state register.
    always_comb begin
        out_next = state_pattern(state_next);
    end

    assign {pump, aerator, valve, heater, uv, feeder} = out_q;
    assign state = state_q;

endmodule

// File: tb/tb_fsm_aquaculture.sv
// tb/tb_fsm_aquaculture.sv - self-checking bench for fsm_aquaculture
module tb_fsm_aquaculture;

    localparam int RC = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i1;
    logic       i0;
    logic       pump, aerator, valve, heater, uv, feeder;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    // Reference model: named states, a dwell count of RECOVERY clocks spent,
    // and the two-deep delay the synchronizers impose on the input code.
    int         m_st;
    int         m_dwell;
    logic [1:0] m_s1, m_s2;
    bit         m_fresh;

    always #5 clk = ~clk;

    fsm_aquaculture #(.RECOVERY_CYCLES(RC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .I1      (i1),
        .I0      (i0),
        .pump    (pump),
        .aerator (aerator),
        .valve   (valve),
        .heater  (heater),
        .uv      (uv),
        .feeder  (feeder),
        .state   (state)
    );

    function automatic logic [5:0] pattern(input int s);
        case (s)
            0:       return 6'b110001;
            1:       return 6'b110010;
            2:       return 6'b111110;
            default: return 6'b110010;
        endcase
    endfunction

    task automatic model_reset();
        m_st    = 0;
        m_dwell = 0;
        m_s1    = 2'b00;
        m_s2    = 2'b00;
        m_fresh = 1'b1;
    endtask

    task automatic model_edge();
        logic [1:0] c;
        c    = m_s2;
        m_s2 = m_s1;
        m_s1 = {i1, i0};
        if (m_st == 0 || m_st == 1) begin
            m_st = c[1] ? 2 : (c == 2'b01 ? 1 : 0);
        end else if (m_st == 2) begin
            if (!c[1]) begin
                m_st    = 3;
                m_dwell = 1;
            end
        end else begin
            if (c[1])              m_st = 2;
            else if (m_dwell == RC) m_st = (c == 2'b01) ? 1 : 0;
            else                    m_dwell++;
        end
        m_fresh = 1'b0;
    endtask

    task automatic check(input string tag);
        logic [7:0] obs, exp;
        obs = {state, pump, aerator, valve, heater, uv, feeder};
        exp = {2'(m_st), (m_fresh ? 6'b000000 : pattern(m_st))};
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic expect_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step(input logic [1:0] code, input int n, input string tag);
        {i1, i0} = code;
        repeat (n) begin
            tick();
            check(tag);
        end
    endtask

    initial begin
        int recov_cnt;
        bit saw_normal;

        // Reset with I=00.
        rst_n = 1'b0;
        {i1, i0} = 2'b00;
        model_reset();
        #12;
        check("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("reset_release");
        expect_bit("release_feeder", feeder, 1'b1);

        step(2'b00, 2, "normal");
        step(2'b01, 3, "warning");
        expect_bit("warning_uv", uv, 1'b1);
        step(2'b10, 3, "critical");
        expect_bit("critical_valve", valve, 1'b1);
        step(2'b11, 2, "fault");

        // Recovery dwell: count RECOVERY clocks, must be exactly RC.
        {i1, i0} = 2'b00;
        recov_cnt = 0;
        repeat (RC + 5) begin
            tick();
            check("recovery");
            if (state == 2'b11) recov_cnt++;
        end
        tests++;
        assert (recov_cnt === RC)
        else begin
            fails++;
            $error("FAIL recovery_len observed=%0d expected=%0d", recov_cnt, RC);
        end

        // Bad condition during RECOVERY returns to CRITICAL without NORMAL.
        step(2'b10, 3, "crit_again");
        {i1, i0} = 2'b00;
        repeat (2) begin
            tick();
            check("to_recovery");
        end
        tick();
        check("recovery_clk1");
        {i1, i0} = 2'b10;
        saw_normal = 1'b0;
        repeat (3) begin
            tick();
            check("override");
            if (state == 2'b00) saw_normal = 1'b1;
        end
        expect_bit("override_no_normal", saw_normal, 1'b0);

        // Short reset pulse while CRITICAL: outputs clear without a clock edge.
        step(2'b10, 2, "crit_hold");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset");
        #2;
        rst_n = 1'b1;
        {i1, i0} = 2'b00;
        repeat (3) begin
            tick();
            check("after_reset");
        end

        // Sub-period glitches between edges must be invisible.
        repeat (4) begin
            #2 i1 = 1'b1;
            #3 i1 = 1'b0;
            tick();
            check("glitch");
        end

        // Randomized code sequence with occasional async resets.
        repeat (120) begin
            logic [1:0] code;
            code = 2'($urandom_range(0, 3));
            step(code, int'($urandom_range(1, 7)), "random");
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("random_reset");
                #1;
                rst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
